// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: shared state encoding and frame-geometry helpers for frame_sequencer.
package frame_seq_pkg;

    typedef enum logic {FILL, DRAIN} state_t;

    localparam int FRAME_DEPTH = 16;
    localparam int LAST_ADDR = FRAME_DEPTH - 1;

    function automatic int last_addr(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/buffer_module.sv
// buffer_module: single-port frame store; registers the addressed word on every non-write tick.
module buffer_module #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     operational_clock,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     write,
    input  logic                     output_enable,
    output logic [DATA_WIDTH-1:0]    data_out
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (operational_clock) begin
            if (write) mem[address] <= data_in;
            else q <= mem[address];
        end
    end

    assign data_out = output_enable ? q : '0;

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: fills buffer_module with one frame, then drains it in address order
// as a valid/ready stream with a last flag.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH = FRAME_DEPTH,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     operational_clock,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [ADDRESS_WIDTH-1:0] buf_address,
    output logic [DATA_WIDTH-1:0]    buf_data,
    output logic                     buf_write,
    output logic                     buf_output_enable,
    input  logic [DATA_WIDTH-1:0]    buf_data_out,
    output logic                     frame_busy
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(last_addr(DEPTH));
    localparam logic [ADDRESS_WIDTH:0] FULL = (ADDRESS_WIDTH+1)'(DEPTH);

    state_t state, state_next;
    logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDRESS_WIDTH:0] issued_count;
    logic pending, handshake, issue;

    always_comb begin
        state_next = state;
        handshake = out_valid & out_ready;
        issue = (state == DRAIN) && !pending && (issued_count < FULL) && (!out_valid || out_ready);
        in_ready = (state == FILL);
        buf_write = (state == FILL) & in_valid;
        buf_address = (state == FILL) ? wr_ptr : rd_ptr;
        buf_data = in_data;
        buf_output_enable = (state == DRAIN);
        frame_busy = (state == DRAIN);
        if (state == FILL && in_valid && wr_ptr == LAST) state_next = DRAIN;
        if (state == DRAIN && handshake && out_last) state_next = FILL;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else if (operational_clock) state <= state_next;
    end

    // Issue waits for the output slot to be free, so a capture never lands on a stalled sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            issued_count <= '0;
            pending <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (operational_clock) begin
            if (state == FILL && in_valid) wr_ptr <= wr_ptr + 1'b1;
            if (issue) begin
                pending <= 1'b1;
                rd_ptr <= rd_ptr + 1'b1;
                issued_count <= issued_count + 1'b1;
            end
            if (pending) begin
                out_data <= buf_data_out;
                out_valid <= 1'b1;
                out_last <= (issued_count == FULL);
                pending <= 1'b0;
            end else if (handshake) begin
                out_valid <= 1'b0;
                out_last <= 1'b0;
            end
            if (handshake && out_last) begin
                rd_ptr <= '0;
                issued_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed scenarios for frame_sequencer driving a real buffer_module.
module tb_frame_sequencer;

    logic clk, reset, operational_clock, in_valid, in_ready, out_valid, out_ready, out_last;
    logic buf_write, buf_output_enable, frame_busy;
    logic [15:0] in_data, out_data, buf_data, buf_data_out;
    logic [3:0] buf_address;
    bit alt;
    int checks, failures, cycle;
    logic [15:0] got[$];
    logic [15:0] exp[$];
    bit lastq[$];
    bit inr_at[$];
    int cyc[$];

    frame_sequencer #(.DATA_WIDTH(16), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .operational_clock(operational_clock),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .buf_address(buf_address), .buf_data(buf_data), .buf_write(buf_write),
        .buf_output_enable(buf_output_enable), .buf_data_out(buf_data_out), .frame_busy(frame_busy)
    );

    buffer_module #(.DATA_WIDTH(16), .DEPTH(16)) u_buf (
        .clk(clk), .operational_clock(operational_clock), .address(buf_address),
        .data_in(buf_data), .write(buf_write), .output_enable(buf_output_enable),
        .data_out(buf_data_out)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial begin
        operational_clock = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            operational_clock = alt ? ~operational_clock : 1'b1;
        end
    end

    // Values seen at the falling edge are the ones the next rising edge acts on.
    always @(negedge clk) begin
        if (!reset && operational_clock && out_valid && out_ready) begin
            got.push_back(out_data);
            lastq.push_back(out_last);
            inr_at.push_back(in_ready);
            cyc.push_back(cycle);
        end
    end

    task automatic do_reset();
        reset = 1;
        in_valid = 0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 0;
        got.delete(); exp.delete(); lastq.delete(); inr_at.delete(); cyc.delete();
    endtask

    task automatic send_frame(input logic [15:0] base, input int n, input bit rnd);
        int i = 0;
        int guard = 0;
        logic [15:0] d = rnd ? 16'($urandom) : base;
        while (i < n && guard < 3000) begin
            in_data = d;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready && operational_clock) begin
                exp.push_back(d);
                i++;
                d = rnd ? 16'($urandom) : base + 16'(i);
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 0;
        checks++;
        if (i != n) begin failures++; $display("FAIL send_timeout accepted=%0d required=%0d", i, n); end
    endtask

    task automatic wait_out(input int n);
        int guard = 0;
        while (got.size() < n && guard < 600) begin @(posedge clk); #1; guard++; end
        checks++;
        if (got.size() < n) begin failures++; $display("FAIL wait_out_timeout got=%0d required=%0d", got.size(), n); end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (frame_busy !== 1'b0) begin failures++; $display("FAIL reset_frame_busy got=%b exp=0", frame_busy); end
        checks++; if (buf_address !== 4'd0) begin failures++; $display("FAIL reset_buf_address got=%0d exp=0", buf_address); end
        checks++; if (buf_output_enable !== 1'b0) begin failures++; $display("FAIL reset_buf_oe got=%b exp=0", buf_output_enable); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        do_reset();
        send_frame(16'h0001, 16, 0);
        checks++; if (in_ready !== 1'b0 || frame_busy !== 1'b1) begin failures++; $display("FAIL basic_enter_drain in_ready=%b busy=%b exp in_ready=0 busy=1", in_ready, frame_busy); end
        checks++; if (buf_output_enable !== 1'b1 || buf_write !== 1'b0) begin failures++; $display("FAIL basic_drain_buf oe=%b wr=%b exp oe=1 wr=0", buf_output_enable, buf_write); end
        in_valid = 1;
        in_data = 16'h0010;
        wait_out(16);
        checks++; if (in_ready !== 1'b1 || frame_busy !== 1'b0) begin failures++; $display("FAIL basic_back_to_fill in_ready=%b busy=%b exp in_ready=1 busy=0", in_ready, frame_busy); end
        in_valid = 0;
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++; if (got[i] !== 16'(i + 1)) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, got[i], 16'(i + 1)); end
            checks++; if (lastq[i] !== (i == 15)) begin failures++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, lastq[i], i == 15); end
            if (i > 0) begin
                checks++; if (cyc[i] - cyc[i-1] != 2) begin failures++; $display("FAIL basic_spacing[%0d] got=%0d exp=2", i, cyc[i] - cyc[i-1]); end
            end
        end
        if (inr_at.size() >= 16) begin
            checks++; if (inr_at[15] !== 1'b0) begin failures++; $display("FAIL basic_in_ready_on_last got=%b exp=0", inr_at[15]); end
        end
    endtask

    task automatic test_stall();
        bit stalled = 0;
        int guard = 0;
        do_reset();
        send_frame(16'h0001, 16, 0);
        while (got.size() < 16 && guard < 600) begin
            @(posedge clk); #1;
            guard++;
            if (!stalled && out_valid && out_data == 16'h0005) begin
                out_ready = 0;
                repeat (5) begin
                    @(posedge clk); #1;
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== 16'h0005 || out_last !== 1'b0) begin
                        failures++; $display("FAIL stall_hold valid=%b data=%h last=%b exp valid=1 data=0005 last=0", out_valid, out_data, out_last);
                    end
                end
                out_ready = 1;
                stalled = 1;
            end
        end
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (!stalled) begin failures++; $display("FAIL stall_seen got=0 exp=1"); end
        checks++; if (got.size() != 16) begin failures++; $display("FAIL stall_count got=%0d exp=16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++; if (got[i] !== 16'(i + 1)) begin failures++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, got[i], 16'(i + 1)); end
        end
    endtask

    task automatic test_alternate();
        bit done = 0;
        int bad = 0;
        do_reset();
        alt = 1;
        fork
            begin
                send_frame(16'h0001, 16, 0);
                wait_out(16);
                done = 1;
            end
            begin
                logic [26:0] prev, snap;
                bit prev_oc = 1;
                int g = 0;
                prev = '0;
                while (!done && g < 2000) begin
                    @(negedge clk);
                    snap = {out_valid, out_last, out_data, in_ready, frame_busy, buf_address, buf_output_enable, 3'b0};
                    if (g > 0 && !prev_oc && snap !== prev) bad++;
                    prev = snap;
                    prev_oc = operational_clock;
                    g++;
                end
            end
        join
        alt = 0;
        checks++; if (bad != 0) begin failures++; $display("FAIL alt_change_off_tick got=%0d exp=0", bad); end
        checks++; if (got.size() != 16) begin failures++; $display("FAIL alt_count got=%0d exp=16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++; if (got[i] !== 16'(i + 1) || lastq[i] !== (i == 15)) begin failures++; $display("FAIL alt_data[%0d] got=%h/%b exp=%h/%b", i, got[i], lastq[i], 16'(i + 1), i == 15); end
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset_fill();
        do_reset();
        send_frame(16'h0040, 7, 0);
        do_reset();
        send_frame(16'h00A0, 16, 0);
        checks++; if (got.size() != 0) begin failures++; $display("FAIL rfill_early_output got=%0d exp=0", got.size()); end
        wait_out(16);
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++; if (got[i] !== 16'h00A0 + 16'(i) || lastq[i] !== (i == 15)) begin failures++; $display("FAIL rfill_data[%0d] got=%h/%b exp=%h/%b", i, got[i], lastq[i], 16'h00A0 + 16'(i), i == 15); end
        end
    endtask

    task automatic test_reset_drain();
        do_reset();
        send_frame(16'h0031, 16, 0);
        wait_out(3);
        reset = 1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_busy !== 1'b0) begin failures++; $display("FAIL rdrain_state valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, frame_busy); end
        checks++; if (buf_address !== 4'd0) begin failures++; $display("FAIL rdrain_addr got=%0d exp=0", buf_address); end
        reset = 0;
        got.delete(); exp.delete(); lastq.delete(); inr_at.delete(); cyc.delete();
        send_frame(16'h00C0, 16, 0);
        wait_out(16);
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++; if (got[i] !== 16'h00C0 + 16'(i)) begin failures++; $display("FAIL rdrain_data[%0d] got=%h exp=%h", i, got[i], 16'h00C0 + 16'(i)); end
        end
    endtask

    task automatic test_random();
        int nlast = 0;
        do_reset();
        send_frame(16'h0000, 32, 1);
        wait_out(32);
        checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < 32 && i < got.size() && i < exp.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got[i], exp[i]); end
            checks++; if (lastq[i] !== (i % 16 == 15)) begin failures++; $display("FAIL rand_last[%0d] got=%b exp=%b", i, lastq[i], i % 16 == 15); end
            nlast += int'(lastq[i]);
        end
        checks++; if (nlast != 2) begin failures++; $display("FAIL rand_last_total got=%0d exp=2", nlast); end
    endtask

    initial begin
        reset = 1;
        in_valid = 0;
        in_data = 0;
        out_ready = 1;
        alt = 0;
        test_reset();
        test_basic();
        test_stall();
        test_alternate();
        test_reset_fill();
        test_reset_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
